// File: rtl/fp_divide_iterative.sv
// IEEE-754 binary32 divider: radix-2 restoring division, one quotient bit per cycle,
// with ready/valid handshake and the ALU's special-case, flush-to-zero and rounding semantics.
module fp_divide_iterative #(
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_data_in,
    output logic        ready,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [2:0]  rounding_mode,
    output logic [31:0] out,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact,
    output logic        invalid_operation,
    output logic        divide_by_zero,
    output logic        valid_data_out
);

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;
    localparam int CW = $clog2(QBITS);

    typedef enum logic [1:0] {IDLE, SPECIAL, DIV, ROUND} state_t;

    typedef struct packed {
        logic [31:0] val;
        logic        ovf;
        logic        unf;
        logic        inx;
        logic        inv;
        logic        dbz;
    } res_t;

    // Denormal operands count as zero here; NaN/inf/zero resolved in priority order.
    function automatic res_t special_result(input logic [31:0] a, input logic [31:0] b);
        res_t res;
        logic s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        res    = '0;
        s      = a[31] ^ b[31];
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        res.unf = (a_zero && (a[22:0] != 23'd0)) || (b_zero && (b[22:0] != 23'd0));
        if (a_nan && a[22]) begin
            res.val = a;
        end else if (b_nan && b[22]) begin
            res.val = b;
        end else if (a_nan) begin
            res.val = a | 32'h0040_0000;
            res.inv = 1'b1;
        end else if (b_nan) begin
            res.val = b | 32'h0040_0000;
            res.inv = 1'b1;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            res.val = 32'h7FC0_0000;
            res.inv = 1'b1;
        end else if (a_inf) begin
            res.val = {s, 8'hFF, 23'd0};
        end else if (b_inf) begin
            res.val = {s, 31'd0};
        end else if (b_zero) begin
            res.val = {s, 8'hFF, 23'd0};
            res.dbz = 1'b1;
        end else begin
            res.val = {s, 31'd0};
        end
        return res;
    endfunction

    function automatic res_t round_result(input logic s, input logic signed [9:0] e,
                                          input logic [QBITS-1:0] q, input logic st,
                                          input logic [2:0] rm);
        res_t res;
        logic [22:0] m;
        logic g, rb, any, inc;
        logic [23:0] sum;
        logic signed [9:0] er;
        res = '0;
        m   = q[24:2];
        g   = q[1];
        rb  = q[0];
        any = g | rb | st;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = s & any;
            RM_RUP:  inc = ~s & any;
            RM_RMM:  inc = g;
            default: inc = g & (rb | st | m[0]);
        endcase
        sum = {1'b0, m} + {23'd0, inc};
        er  = e + (sum[23] ? 10'sd1 : 10'sd0);
        if (er > 10'sd254) begin
            res.ovf = 1'b1;
            res.inx = 1'b1;
            case (rm)
                RM_RTZ:  res.val = {s, 31'h7F7F_FFFF};
                RM_RDN:  res.val = s ? 32'hFF80_0000 : 32'h7F7F_FFFF;
                RM_RUP:  res.val = s ? 32'hFF7F_FFFF : 32'h7F80_0000;
                default: res.val = {s, 31'h7F80_0000};
            endcase
        end else if (er <= 10'sd0) begin
            res.val = {s, 31'd0};
            res.unf = 1'b1;
            res.inx = 1'b1;
        end else begin
            res.val = {s, er[7:0], sum[22:0]};
            res.inx = any;
        end
        return res;
    endfunction

    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic accept, is_special_in, lt_in, ge;
    logic [23:0] ma_in, mb_in;
    logic signed [9:0] exp_in;
    logic [24:0] r_diff;

    logic [31:0] a_r, b_r;
    logic [2:0]  rm_r;
    logic        sign_r;
    logic signed [9:0] exp_r;
    logic [23:0] mb_r;
    logic [24:0] r_r;
    logic [QBITS-1:0] q_r;
    res_t spec_res, rnd_res, res_r;

    assign ready  = (state == IDLE);
    assign accept = valid_data_in & ready;
    assign is_special_in = (in1[30:23] == 8'h00) || (in1[30:23] == 8'hFF) ||
                           (in2[30:23] == 8'h00) || (in2[30:23] == 8'hFF);
    assign ma_in  = {1'b1, in1[22:0]};
    assign mb_in  = {1'b1, in2[22:0]};
    assign lt_in  = ma_in < mb_in;
    // Pre-normalise so the first quotient bit is always 1.
    assign exp_in = $signed({2'b00, in1[30:23]}) - $signed({2'b00, in2[30:23]}) + 10'sd127
                    - (lt_in ? 10'sd1 : 10'sd0);
    assign ge     = r_r >= {1'b0, mb_r};
    assign r_diff = ge ? (r_r - {1'b0, mb_r}) : r_r;

    assign spec_res = special_result(a_r, b_r);
    assign rnd_res  = round_result(sign_r, exp_r, q_r, |r_r, rm_r);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = is_special_in ? SPECIAL : DIV;
            SPECIAL: state_nx = IDLE;
            DIV:     if (cnt == CW'(QBITS - 1)) state_nx = ROUND;
            ROUND:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            res_r          <= '0;
            valid_data_out <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= (state == DIV) ? cnt + CW'(1) : '0;
            valid_data_out <= 1'b0;
            if (state == SPECIAL) begin
                res_r          <= spec_res;
                valid_data_out <= 1'b1;
            end else if (state == ROUND) begin
                res_r          <= rnd_res;
                valid_data_out <= 1'b1;
            end
        end
    end

    // Operand and iteration registers carry no reset; they are always loaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r    <= in1;
            b_r    <= in2;
            rm_r   <= rounding_mode;
            sign_r <= in1[31] ^ in2[31];
            mb_r   <= mb_in;
            r_r    <= lt_in ? {ma_in, 1'b0} : {1'b0, ma_in};
            exp_r  <= exp_in;
            q_r    <= '0;
        end else if (state == DIV) begin
            q_r <= {q_r[QBITS-2:0], ge};
            r_r <= {r_diff[23:0], 1'b0};
        end
    end

    assign out               = res_r.val;
    assign overflow          = res_r.ovf;
    assign underflow         = res_r.unf;
    assign inexact           = res_r.inx;
    assign invalid_operation = res_r.inv;
    assign divide_by_zero    = res_r.dbz;

endmodule

// File: tb/tb_fp_divide_iterative.sv
// Bench for fp_divide_iterative: scoreboard of expected results, per-feature tasks
// covering normal division, specials, overflow/underflow, handshake and reset.
module tb_fp_divide_iterative;

    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RTZ = 3'd1;
    localparam logic [2:0] RDN = 3'd2;
    localparam logic [2:0] RUP = 3'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_data_in = 1'b0;
    logic        ready;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic [2:0]  rounding_mode = '0;
    logic [31:0] out;
    logic        overflow, underflow, inexact, invalid_operation, divide_by_zero, valid_data_out;

    fp_divide_iterative #(.QBITS(26)) dut (
        .clk(clk), .rst_n(rst_n), .valid_data_in(valid_data_in), .ready(ready),
        .in1(in1), .in2(in2), .rounding_mode(rounding_mode), .out(out),
        .overflow(overflow), .underflow(underflow), .inexact(inexact),
        .invalid_operation(invalid_operation), .divide_by_zero(divide_by_zero),
        .valid_data_out(valid_data_out)
    );

    always #5 clk = ~clk;

    // flag vector order: {overflow, underflow, inexact, invalid, divide_by_zero}
    typedef struct {
        logic [31:0] val;
        logic [4:0]  flg;
        string       nm;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rm;
        logic [31:0] ev;
        logic [4:0]  ef;
        string       nm;
        int          lat;
    } op_t;

    exp_t sb[$];
    int   res_hist[$];
    int   checks = 0;
    int   errors = 0;
    int   n_results = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   res_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_data_out) begin
                res_cyc = cyc;
                res_hist.push_back(cyc);
                n_results++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: out=%h arrived with no pending operation", out);
                end else begin
                    e = sb.pop_front();
                    if (out !== e.val) begin
                        errors++;
                        $display("FAIL %s out: got %h expected %h", e.nm, out, e.val);
                    end
                    checks++;
                    if ({overflow, underflow, inexact, invalid_operation, divide_by_zero} !== e.flg) begin
                        errors++;
                        $display("FAIL %s flags(ovf,unf,inx,inv,dbz): got %b expected %b", e.nm,
                                 {overflow, underflow, inexact, invalid_operation, divide_by_zero}, e.flg);
                    end
                end
            end
        end
    end

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                               input logic [31:0] ev, input logic [4:0] ef, input string nm,
                               input int lat);
        op_t o;
        o.a = a; o.b = b; o.rm = rm; o.ev = ev; o.ef = ef; o.nm = nm; o.lat = lat;
        return o;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                        input logic [31:0] ev, input logic [4:0] ef, input string nm,
                        input bit expect_result, output bit ok);
        int budget;
        budget = 100;
        ok = 1'b1;
        while (!ready && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        if (!ready) begin
            ok = 1'b0;
            return;
        end
        in1 = a; in2 = b; rounding_mode = rm; valid_data_in = 1'b1;
        acc_cyc = cyc + 1;
        if (expect_result) sb.push_back('{ev, ef, nm});
        @(negedge clk); #1;
        valid_data_in = 1'b0;
    endtask

    task automatic wait_done(input int start_n, input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            if (n_results != start_n) break;
            @(negedge clk); #1;
        end
        if (n_results != start_n) lat = res_cyc - acc_cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in1 = 32'h40C0_0000; in2 = 32'h4000_0000; valid_data_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++;
        if (out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h expected 00000000", out); end
        checks++;
        if ({overflow, underflow, inexact, invalid_operation, divide_by_zero} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {overflow, underflow, inexact, invalid_operation, divide_by_zero});
        end
        checks++;
        if (valid_data_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_data_out); end
        valid_data_in = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", ready); end
        checks++;
        if (n_results !== 0) begin errors++; $display("FAIL post_reset_results: got %0d expected 0", n_results); end
    endtask

    task automatic test_normal();
        op_t t[$];
        int n0, lat;
        bit ok;
        t.push_back(mk(32'h40C0_0000, 32'h4000_0000, RNE, 32'h4040_0000, 5'b00000, "6div2_rne", 27));
        t.push_back(mk(32'h3F80_0000, 32'h4040_0000, RNE, 32'h3EAA_AAAB, 5'b00100, "1div3_rne", 27));
        t.push_back(mk(32'h3F80_0000, 32'h4040_0000, RTZ, 32'h3EAA_AAAA, 5'b00100, "1div3_rtz", 27));
        foreach (t[i]) begin
            n0 = n_results;
            send(t[i].a, t[i].b, t[i].rm, t[i].ev, t[i].ef, t[i].nm, 1'b1, ok);
            wait_done(n0, 60, lat);
            checks++;
            if (lat !== t[i].lat) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles expected %0d", t[i].nm, lat, t[i].lat);
            end
        end
    endtask

    task automatic test_special();
        op_t t[$];
        int n0, lat;
        bit ok;
        t.push_back(mk(32'h3F80_0000, 32'h0000_0000, RNE, 32'h7F80_0000, 5'b00001, "one_div_zero", 1));
        t.push_back(mk(32'h0000_0000, 32'h0000_0000, RNE, 32'h7FC0_0000, 5'b00010, "zero_div_zero", 1));
        t.push_back(mk(32'h7F80_0001, 32'h3F80_0000, RNE, 32'h7FC0_0001, 5'b00010, "snan_div_x", 1));
        t.push_back(mk(32'h0000_0001, 32'h3F80_0000, RNE, 32'h0000_0000, 5'b01000, "denorm_div_one", 1));
        foreach (t[i]) begin
            n0 = n_results;
            send(t[i].a, t[i].b, t[i].rm, t[i].ev, t[i].ef, t[i].nm, 1'b1, ok);
            wait_done(n0, 20, lat);
            checks++;
            if (lat !== t[i].lat) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles expected %0d", t[i].nm, lat, t[i].lat);
            end
        end
    endtask

    task automatic test_overflow_underflow();
        op_t t[$];
        int n0, lat;
        bit ok;
        t.push_back(mk(32'h0080_0000, 32'h4000_0000, RNE, 32'h0000_0000, 5'b01100, "underflow_rne", 27));
        t.push_back(mk(32'h7F7F_FFFF, 32'h3F00_0000, RNE, 32'h7F80_0000, 5'b10100, "ovf_rne", 27));
        t.push_back(mk(32'h7F7F_FFFF, 32'h3F00_0000, RTZ, 32'h7F7F_FFFF, 5'b10100, "ovf_rtz", 27));
        t.push_back(mk(32'hFF7F_FFFF, 32'h3F00_0000, RUP, 32'hFF7F_FFFF, 5'b10100, "ovf_neg_rup", 27));
        t.push_back(mk(32'hFF7F_FFFF, 32'h3F00_0000, RDN, 32'hFF80_0000, 5'b10100, "ovf_neg_rdn", 27));
        foreach (t[i]) begin
            n0 = n_results;
            send(t[i].a, t[i].b, t[i].rm, t[i].ev, t[i].ef, t[i].nm, 1'b1, ok);
            wait_done(n0, 60, lat);
            checks++;
            if (lat !== t[i].lat) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles expected %0d", t[i].nm, lat, t[i].lat);
            end
        end
    endtask

    task automatic test_reset_mid_div();
        int n0, lat;
        bit ok;
        n0 = n_results;
        send(32'h40C0_0000, 32'h4000_0000, RNE, 32'h0, 5'b0, "aborted", 1'b0, ok);
        repeat (9) @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL mid_div_busy: ready got %b expected 0", ready); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL mid_div_reset_ready: got %b expected 1", ready); end
        checks++;
        if (out !== 32'h0) begin errors++; $display("FAIL mid_div_reset_out: got %h expected 00000000", out); end
        checks++;
        if ({overflow, underflow, inexact, invalid_operation, divide_by_zero} !== 5'b0) begin
            errors++;
            $display("FAIL mid_div_reset_flags: got %b expected 00000",
                     {overflow, underflow, inexact, invalid_operation, divide_by_zero});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if (n_results !== n0) begin
            errors++;
            $display("FAIL mid_div_no_pulse: got %0d results expected %0d", n_results - n0, 0);
        end
        n0 = n_results;
        send(32'h40C0_0000, 32'h4000_0000, RNE, 32'h4040_0000, 5'b00000, "6div2_after_reset", 1'b1, ok);
        wait_done(n0, 60, lat);
        checks++;
        if (lat !== 27) begin errors++; $display("FAIL after_reset_latency: got %0d expected 27", lat); end
    endtask

    task automatic test_back_to_back();
        int n0, lat, t1;
        bit ok;
        n0 = n_results;
        send(32'h3F80_0000, 32'h0000_0000, RNE, 32'h7F80_0000, 5'b00001, "b2b_first", 1'b1, ok);
        wait_done(n0, 20, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 1", lat); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_with_valid: got %b expected 1", ready); end
        t1 = res_cyc;
        n0 = n_results;
        send(32'h0000_0000, 32'h0000_0000, RNE, 32'h7FC0_0000, 5'b00010, "b2b_second", 1'b1, ok);
        checks++;
        if (valid_data_out !== 1'b0) begin
            errors++;
            $display("FAIL valid_pulse_width: got %b expected 0", valid_data_out);
        end
        wait_done(n0, 20, lat);
        checks++;
        if (res_cyc - t1 !== 2) begin errors++; $display("FAIL b2b_spacing: got %0d expected 2", res_cyc - t1); end
    endtask

    task automatic test_hold_valid();
        int n0, h0, pushes;
        n0 = n_results;
        h0 = res_hist.size();
        pushes = 0;
        in1 = 32'h40C0_0000; in2 = 32'h4000_0000; rounding_mode = RNE;
        valid_data_in = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (ready) begin
                sb.push_back('{32'h4040_0000, 5'b00000, "hold_valid"});
                pushes++;
            end
            @(negedge clk); #1;
        end
        valid_data_in = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (n_results - n0 >= 3) break;
            @(negedge clk); #1;
        end
        repeat (30) @(negedge clk);
        #1;
        checks++;
        if (pushes !== 3) begin errors++; $display("FAIL hold_accepts: got %0d expected 3", pushes); end
        checks++;
        if (n_results - n0 !== 3) begin errors++; $display("FAIL hold_results: got %0d expected 3", n_results - n0); end
        if (res_hist.size() >= h0 + 3) begin
            checks++;
            if (res_hist[h0+1] - res_hist[h0] !== 28 || res_hist[h0+2] - res_hist[h0+1] !== 28) begin
                errors++;
                $display("FAIL hold_spacing: got %0d,%0d expected 28,28",
                         res_hist[h0+1] - res_hist[h0], res_hist[h0+2] - res_hist[h0+1]);
            end
        end
    endtask

    task automatic test_drop_mid_div();
        int n0, lat;
        bit ok;
        n0 = n_results;
        send(32'h40C0_0000, 32'h4000_0000, RNE, 32'h4040_0000, 5'b00000, "drop_first", 1'b1, ok);
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL drop_busy: ready got %b expected 0", ready); end
        in1 = 32'h3F80_0000; in2 = 32'h4040_0000; valid_data_in = 1'b1;
        @(negedge clk); #1;
        valid_data_in = 1'b0;
        wait_done(n0, 60, lat);
        checks++;
        if (lat !== 27) begin errors++; $display("FAIL drop_latency: got %0d expected 27", lat); end
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if (n_results - n0 !== 1) begin errors++; $display("FAIL drop_result_count: got %0d expected 1", n_results - n0); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_overflow_underflow();
        test_reset_mid_div();
        test_back_to_back();
        test_hold_valid();
        test_drop_mid_div();
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL pending_results: got %0d expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
